// File: rtl/tick_rate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tick_rate_controller
// Description : Programmable tick generator and clock divider. The half-period
//               can be changed on the fly without truncating a clk_out phase.
//               Optional tick counter enabled by macro TICK_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_rate_controller #(
    parameter int FREC_IN          = 100000000,
    parameter int DEFAULT_FREC_OUT = 30,
    parameter int DIV_WIDTH        = 32
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 div_req,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 div_ack,
    output logic                 div_err,
    output logic                 tick,
    output logic                 clk_out,
    output logic [DIV_WIDTH-1:0] active_div,
    output logic [15:0]          tick_count
);

    localparam logic [DIV_WIDTH-1:0] c_RESET_DIV =
        DIV_WIDTH'(FREC_IN / (2 * DEFAULT_FREC_OUT));
    localparam logic [DIV_WIDTH-1:0] c_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] w_count_nxt;
    logic [DIV_WIDTH-1:0] r_active;
    logic [DIV_WIDTH-1:0] w_active_nxt;
    logic [DIV_WIDTH-1:0] r_pending;
    logic [DIV_WIDTH-1:0] w_pending_nxt;
    logic                 r_clk_out;
    logic                 w_clk_out_nxt;
    logic                 r_tick;
    logic                 w_tick_nxt;
    logic                 r_ack;
    logic                 r_err;

    logic                 w_sample;
    logic                 w_zero;
    logic                 w_valid;
    logic                 w_term;

    // A request is only sampled while no acknowledge is outstanding
    assign w_sample = div_req & ~r_ack;
    assign w_zero   = (div_value == '0);
    assign w_valid  = w_sample & ~w_zero;
    assign w_term   = (r_state != STOP) && (r_count == (r_active - c_ONE));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state   <= STOP;
            r_count   <= '0;
            r_active  <= c_RESET_DIV;
            r_pending <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_clk_out <= w_clk_out_nxt;
            r_tick    <= w_tick_nxt;
            r_ack     <= w_sample;
            r_err     <= w_sample & w_zero;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_clk_out_nxt = r_clk_out;
        w_tick_nxt    = 1'b0;

        case (r_state)
            STOP: begin
                w_count_nxt   = '0;
                w_clk_out_nxt = 1'b0;
                if (w_valid) begin
                    w_active_nxt = div_value;
                end
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end

            RUN: begin
                if (!enable) begin
                    w_state_nxt   = STOP;
                    w_count_nxt   = '0;
                    w_clk_out_nxt = 1'b0;
                    if (w_valid) begin
                        w_active_nxt = div_value;
                    end
                end else begin
                    if (w_term) begin
                        w_count_nxt   = '0;
                        w_tick_nxt    = 1'b1;
                        w_clk_out_nxt = ~r_clk_out;
                    end else begin
                        w_count_nxt = r_count + c_ONE;
                    end
                    if (w_valid) begin
                        w_pending_nxt = div_value;
                        w_state_nxt   = PEND;
                    end
                end
            end

            PEND: begin
                if (!enable) begin
                    // Stopping commits the newest value so the next run uses it
                    w_state_nxt   = STOP;
                    w_count_nxt   = '0;
                    w_clk_out_nxt = 1'b0;
                    w_active_nxt  = w_valid ? div_value : r_pending;
                end else begin
                    if (w_term) begin
                        w_count_nxt   = '0;
                        w_tick_nxt    = 1'b1;
                        w_clk_out_nxt = ~r_clk_out;
                        w_active_nxt  = r_pending;
                        if (!w_valid) begin
                            w_state_nxt = RUN;
                        end
                    end else begin
                        w_count_nxt = r_count + c_ONE;
                    end
                    if (w_valid) begin
                        w_pending_nxt = div_value;
                    end
                end
            end

            default: begin
                w_state_nxt   = STOP;
                w_count_nxt   = '0;
                w_clk_out_nxt = 1'b0;
            end
        endcase
    end

`ifdef TICK_COUNTER_EN
    logic [15:0] r_tick_count;

    // Advances on the same edge that raises tick, so both change together
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_tick_count <= 16'd0;
        end else if (w_tick_nxt) begin
            r_tick_count <= r_tick_count + 16'd1;
        end
    end

    assign tick_count = r_tick_count;
`else
    assign tick_count = 16'd0;
`endif

    assign div_ack    = r_ack;
    assign div_err    = r_err;
    assign tick       = r_tick;
    assign clk_out    = r_clk_out;
    assign active_div = r_active;

endmodule
`default_nettype wire

// File: tb/tb_tick_rate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_rate_controller
// Description : Directed plus randomized bench for tick_rate_controller with
//               an elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_rate_controller;

    localparam int FREC_IN = 100;
    localparam int DEF_OUT = 10;
    localparam int DW      = 32;
    localparam logic [DW-1:0] RST_DIV = DW'(FREC_IN / (2 * DEF_OUT));

    logic          clk_in = 1'b0;
    logic          reset;
    logic          enable;
    logic          div_req;
    logic [DW-1:0] div_value;
    logic          div_ack;
    logic          div_err;
    logic          tick;
    logic          clk_out;
    logic [DW-1:0] active_div;
    logic [15:0]   tick_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: "running" flag, cycles elapsed in the current half
    // period, and an optional queued half-period.
    bit          m_running;
    logic [DW-1:0] m_elapsed;
    logic [DW-1:0] m_div;
    bit          m_pend_valid;
    logic [DW-1:0] m_pend_val;
    bit          m_clk;
    bit          m_tick;
    bit          m_ack;
    bit          m_err;
    logic [15:0] m_tcount;

    tick_rate_controller #(
        .FREC_IN         (FREC_IN),
        .DEFAULT_FREC_OUT(DEF_OUT),
        .DIV_WIDTH       (DW)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .div_req   (div_req),
        .div_value (div_value),
        .div_ack   (div_ack),
        .div_err   (div_err),
        .tick      (tick),
        .clk_out   (clk_out),
        .active_div(active_div),
        .tick_count(tick_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running    = 1'b0;
        m_elapsed    = '0;
        m_div        = RST_DIV;
        m_pend_valid = 1'b0;
        m_pend_val   = '0;
        m_clk        = 1'b0;
        m_tick       = 1'b0;
        m_ack        = 1'b0;
        m_err        = 1'b0;
        m_tcount     = 16'd0;
    endtask

    task automatic model_edge();
        bit sample;
        bit valid;
        sample = (div_req === 1'b1) && !m_ack;
        valid  = sample && (div_value != '0);
        m_ack  = sample;
        m_err  = sample && (div_value == '0);
        m_tick = 1'b0;
        if (!m_running) begin
            if (valid) m_div = div_value;
            m_elapsed = '0;
            m_clk     = 1'b0;
            m_running = (enable === 1'b1);
        end else if (enable !== 1'b1) begin
            if (valid) m_div = div_value;
            else if (m_pend_valid) m_div = m_pend_val;
            m_pend_valid = 1'b0;
            m_running    = 1'b0;
            m_elapsed    = '0;
            m_clk        = 1'b0;
        end else begin
            if (m_elapsed + 1 == m_div) begin
                m_tick    = 1'b1;
                m_clk     = !m_clk;
                m_elapsed = '0;
`ifdef TICK_COUNTER_EN
                m_tcount  = m_tcount + 16'd1;
`endif
                if (m_pend_valid) begin
                    m_div        = m_pend_val;
                    m_pend_valid = 1'b0;
                end
            end else begin
                m_elapsed = m_elapsed + 1;
            end
            if (valid) begin
                m_pend_valid = 1'b1;
                m_pend_val   = div_value;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk($sformatf("%s/tick", tag), DW'(tick), DW'(m_tick));
        chk($sformatf("%s/clk_out", tag), DW'(clk_out), DW'(m_clk));
        chk($sformatf("%s/div_ack", tag), DW'(div_ack), DW'(m_ack));
        chk($sformatf("%s/div_err", tag), DW'(div_err), DW'(m_err));
        chk($sformatf("%s/active_div", tag), active_div, m_div);
        chk($sformatf("%s/tick_count", tag), DW'(tick_count), DW'(m_tcount));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk_in);
        #1;
        compare_all(tag);
    endtask

    // Requester: hold div_req until the acknowledge appears
    task automatic req(input string tag, input logic [DW-1:0] v);
        div_req   = 1'b1;
        div_value = v;
        for (int i = 0; i < 4; i++) begin
            step(tag);
            if (m_ack) break;
        end
        div_req = 1'b0;
    endtask

    task automatic steps_to_tick(input string tag, input int maxn, output int n);
        n = maxn + 1;
        for (int i = 1; i <= maxn; i++) begin
            step(tag);
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_in);
        #2;
        reset   = 1'b1;
        div_req = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(posedge clk_in);
        #1;
        compare_all(tag);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int first;
        int nt;
        reset     = 1'b0;
        enable    = 1'b0;
        div_req   = 1'b0;
        div_value = '0;
        model_reset();

        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #2 compare_all("reset");
        @(posedge clk_in); #1 compare_all("reset_hold");
        @(negedge clk_in);
        reset  = 1'b0;
        enable = 1'b1;

        // Reset divider of 5: first tick 5 cycles after the enable edge
        first = 0;
        nt    = 0;
        for (int i = 1; i <= 26; i++) begin
            step("run5");
            if (tick === 1'b1) begin
                nt++;
                if (first == 0) first = i;
            end
        end
        chk("run5_first_tick", DW'(first), 32'd6);
        chk("run5_num_ticks", DW'(nt), 32'd5);

        // Request 3 while counter is 1
        for (int i = 0; i < 10; i++) begin
            if (m_running && m_elapsed == 1) break;
            step("align3");
        end
        req("req3", 32'd3);
        steps_to_tick("req3_old", 8, n);
        chk("req3_old_half_end", DW'(n), 32'd3);
        chk("req3_applied", active_div, 32'd3);
        steps_to_tick("req3_new", 8, n);
        chk("req3_new_spacing", DW'(n), 32'd3);

        // Move to 6, then queue 7 and overwrite with 2
        req("req6", 32'd6);
        steps_to_tick("req6_wait", 8, n);
        chk("req6_applied", active_div, 32'd6);
        req("req7", 32'd7);
        req("req2", 32'd2);
        steps_to_tick("latest_old", 10, n);
        chk("latest_old_half_end", DW'(n), 32'd3);
        chk("latest_applied", active_div, 32'd2);
        steps_to_tick("latest_new", 10, n);
        chk("latest_spacing", DW'(n), 32'd2);

        // Zero request rejected
        req("req0", 32'd0);
        chk("zero_ack", DW'(div_ack), 32'd1);
        chk("zero_err", DW'(div_err), 32'd1);
        chk("zero_active", active_div, 32'd2);
        steps_to_tick("zero_a", 4, n);
        chk("zero_spacing_a", DW'(n), 32'd1);
        steps_to_tick("zero_b", 4, n);
        chk("zero_spacing_b", DW'(n), 32'd2);

        // Pending value committed when stopping
        req("req9", 32'd9);
        steps_to_tick("req9_wait", 4, n);
        steps_to_tick("req9_run", 12, n);
        chk("req9_spacing", DW'(n), 32'd9);
        req("req4", 32'd4);
        enable = 1'b0;
        step("disable");
        chk("disable_active", active_div, 32'd4);
        chk("disable_clk_out", DW'(clk_out), 32'd0);
        chk("disable_tick", DW'(tick), 32'd0);
        step("stopped");
        enable = 1'b1;
        steps_to_tick("reenable", 10, n);
        chk("reenable_first_tick", DW'(n), 32'd5);

        // Reset during a handshake drops the request
        div_req   = 1'b1;
        div_value = 32'd3;
        async_reset("rst_handshake");
        steps_to_tick("after_rst", 10, n);
        chk("after_rst_first_tick", DW'(n), 32'd6);
        chk("after_rst_active", active_div, RST_DIV);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (div_req && m_ack) begin
                div_req = 1'b0;
            end else if (!div_req && $urandom_range(0, 3) == 0) begin
                div_req   = 1'b1;
                div_value = DW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
            else step("rand");
        end

`ifdef TICK_COUNTER_EN
        // Divider of 1 and tick counter wrap
        enable = 1'b1;
        async_reset("tc_pre");
        req("req1", 32'd1);
        for (int i = 0; i < 70000; i++) begin
            if (m_tcount == 16'hFFFF) break;
            step("tc_run");
        end
        chk("tc_at_max", DW'(tick_count), 32'h0000FFFF);
        step("tc_wrap");
        chk("tc_wrapped", DW'(tick_count), 32'd0);
        for (int i = 0; i < 5; i++) step("tc_more");
        async_reset("tc_reset");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_rate_controller.md
TICK_RATE_CONTROLLER -- requirements
Module: tick_rate_controller

Interface
REQ-001 The module SHALL have parameter FREC_IN, default 100000000, input clock frequency in Hz.
REQ-002 The module SHALL have parameter DEFAULT_FREC_OUT, default 30, output frequency in Hz after reset.
REQ-003 The module SHALL have parameter DIV_WIDTH, default 32, width of all half-period values.
REQ-004 The module SHALL have port clk_in, input, 1, the single clock; all state on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, asynchronous and active-high.
REQ-006 The module SHALL have port enable, input, 1, run (1) or stop (0) the divider.
REQ-007 The module SHALL have port div_req, input, 1, request to load a new half-period.
REQ-008 The module SHALL have port div_value, input, DIV_WIDTH, requested half-period in clk_in cycles.
REQ-009 The module SHALL have port div_ack, output, 1, one-cycle acceptance pulse.
REQ-010 The module SHALL have port div_err, output, 1, one-cycle pulse, coincident with div_ack, marking a rejected value.
REQ-011 The module SHALL have port tick, output, 1, one-cycle pulse at each half-period end.
REQ-012 The module SHALL have port clk_out, output, 1, divided clock; toggles on each tick.
REQ-013 The module SHALL have port active_div, output, DIV_WIDTH, half-period currently in use.
REQ-014 The module SHALL have port tick_count, output, 16, tick counter (see Configuration).

Function
REQ-015 The FSM SHALL have states STOP, RUN and PEND (new value waiting to be applied).
REQ-016 In STOP, the internal counter SHALL be held at 0, clk_out held at 0 and tick held at 0.
REQ-017 STOP->RUN SHALL occur on the first edge with enable=1; counting starts from 0 on that edge.
REQ-018 In RUN/PEND, the counter SHALL increment each cycle; at counter==active_div-1 it wraps to 0, tick=1 for that one cycle (registered) and clk_out inverts on the same edge.
REQ-019 A request SHALL be sampled only when div_req=1 and div_ack=0; div_ack SHALL be high in the cycle after sampling (1-cycle latency) and requesters hold div_req until they see div_ack.
REQ-020 A sampled div_value of 0 SHALL be discarded, with div_ack=1 and div_err=1; no state change.
REQ-021 A valid request in STOP SHALL load active_div directly on the sampling edge.
REQ-022 A valid request in RUN SHALL latch into a pending register and move to PEND; the current half-period completes with the old value.
REQ-023 In PEND, at the terminal count, active_div SHALL take the pending value, the counter SHALL restart at 0 and the FSM SHALL return to RUN; no clk_out half-period is ever truncated.
REQ-024 A valid request in PEND SHALL overwrite the pending value (latest wins).
REQ-025 A request sampled on the same edge as the PEND terminal count SHALL be applied as follows: the old pending value is applied and the new value becomes pending, and the FSM stays in PEND.
REQ-026 enable=0 in RUN/PEND SHALL go to STOP on the next edge; from PEND, the pending value SHALL be applied to active_div on that edge.
REQ-027 div_value=1 SHALL be legal: tick every cycle, clk_out at FREC_IN/2.

Reset
REQ-028 reset=1 SHALL immediately force: state STOP, counter 0, clk_out 0, tick 0, div_ack 0, div_err 0, tick_count 0, pending 0, active_div = FREC_IN/(2*DEFAULT_FREC_OUT) (integer division).
REQ-029 Reset mid-handshake SHALL drop any pending or unacknowledged request; the requester must re-request.

Configuration
REQ-030 With macro TICK_COUNTER_EN defined, tick_count SHALL increment by 1 on every tick, wrap from 65535 to 0 and hold its value in STOP.
REQ-031 Without TICK_COUNTER_EN, tick_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification (FREC_IN=100, DEFAULT_FREC_OUT=10, so reset active_div=5)
REQ-032 Reset, enable=1 -> tick every 5 cycles, clk_out period 10 cycles, active_div=5.
REQ-033 In RUN, request 3 at counter=1 -> div_ack next cycle; old half-period ends at counter 4; following ticks every 3 cycles; no short clk_out phase.
REQ-034 In PEND, request 7 then 2 before the terminal count -> active_div becomes 2 at the terminal count; 7 is never used.
REQ-035 Request 0 -> div_ack=1 and div_err=1 in the same cycle; active_div and tick spacing remain unchanged.
REQ-036 Request 4 while in PEND, then enable=0 -> STOP on the next edge, active_div=4, clk_out=0; re-enable gives first tick after 4 cycles.
REQ-037 With TICK_COUNTER_EN defined and div_value=1 -> tick_count wraps 65535->0 after 65536 ticks; reset asserted mid-count -> all outputs at reset values immediately, without waiting for a clock edge.
